lfo_ctrl: RTL and testbench

Sequencing controller for the triangle LFO used by the modulation effects (tremolo/vibrato). It drives the LFO start and 3-bit rate select (0..7 = 1..8 Hz) from user rate-up/down pulses and the effect enable. Rate changes and stops are deferred to an LFO turning point (peak/trough) so modulation never shows a slope discontinuity mid-ramp. A timeout backstop guarantees that every deferred action completes.

---
 rtl/lfo_pkg.sv | 35 +++
 rtl/lfo_turn_detect.sv | 54 +++++
 rtl/lfo_ctrl.sv | 132 +++++++++++++
 tb/tb_lfo_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lfo_pkg.sv
// Shared types and constants for the LFO sequencing controller and its turn detector.
package lfo_pkg;

  localparam int          LFO_W    = 32;
  localparam logic [2:0]  FREQ_MIN = 3'd0;
  localparam logic [2:0]  FREQ_MAX = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PEND,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // One saturating rate step; simultaneous up/down cancel out.
  function automatic logic [2:0] rate_step(input logic [2:0] freq,
                                           input logic       up,
                                           input logic       down);
    logic [2:0] result;
    result = freq;
    if (up && !down && (freq != FREQ_MAX)) begin
      result = freq + 3'd1;
    end else if (down && !up && (freq != FREQ_MIN)) begin
      result = freq - 3'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lfo_turn_detect.sv
// Detects LFO turning points (peak/trough) from successive signed samples.
// o_turn_now is the same-cycle decision; o_turn is its registered one-cycle strobe.
module lfo_turn_detect #(
  parameter int LFO_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [LFO_W-1:0] i_lfo,
  output logic             o_turn_now,
  output logic             o_turn
);
  import lfo_pkg::*;

  logic [LFO_W-1:0] r_prev_lfo;
  dir_t             r_dir;
  dir_t             w_dir;
  logic             r_turn;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    w_dir = DIR_NONE;
    if ($signed(i_lfo) > $signed(r_prev_lfo)) begin
      w_dir = DIR_UP;
    end else if ($signed(i_lfo) < $signed(r_prev_lfo)) begin
      w_dir = DIR_DOWN;
    end
  end

  // A flat sample is not a direction; the LFO dwells one cycle at each turn.
  assign o_turn_now = (w_dir != DIR_NONE) && (r_dir != DIR_NONE) && (w_dir != r_dir);
  assign o_turn     = r_turn;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register. Reset is synchronous here:
  // i_rst_n is only looked at on the clock edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev_lfo <= '0;
      r_dir      <= DIR_NONE;
      r_turn     <= 1'b0;
    end else begin
      r_prev_lfo <= i_lfo;
      r_turn     <= o_turn_now;
      if (i_clear) begin
        r_dir <= DIR_NONE;
      end else if (w_dir != DIR_NONE) begin
        r_dir <= w_dir;
      end
    end
  end

endmodule

// File: rtl/lfo_ctrl.sv
// Sequencing controller for the triangle LFO: start/rate select with rate changes
// and stops deferred to an LFO turning point, backed by a timeout.
module lfo_ctrl #(
  parameter int         LFO_W          = lfo_pkg::LFO_W,
  parameter logic [2:0] FREQ_RESET     = 3'd0,
  parameter int         TIMEOUT_CYCLES = 60000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_rate_up,
  input  logic             i_rate_down,
  input  logic [LFO_W-1:0] i_lfo,
  output logic             o_start,
  output logic [2:0]       o_freq,
  output logic             o_pending,
  output logic             o_turn
);
  import lfo_pkg::*;

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_freq;
  logic [2:0]         w_freq_nxt;
  logic [2:0]         r_pend_freq;
  logic [2:0]         w_pend_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [TIMER_W-1:0] w_timer_inc;
  logic [2:0]         w_target_run;
  logic [2:0]         w_target_pend;
  logic               w_timeout;
  logic               w_turn_now;
  logic               w_clear;

  lfo_turn_detect #(
    .LFO_W (LFO_W)
  ) u_turn_detect (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_lfo      (i_lfo),
    .o_turn_now (w_turn_now),
    .o_turn     (o_turn)
  );

  assign w_target_run  = rate_step(r_freq, i_rate_up, i_rate_down);
  assign w_target_pend = rate_step(r_pend_freq, i_rate_up, i_rate_down);
  assign w_timeout     = (r_timer == TIMER_LAST);
  // Saturating increment: the timer must never wrap back below TIMER_LAST.
  assign w_timer_inc   = (r_timer == TIMER_MAX) ? r_timer : r_timer + TIMER_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_freq_nxt  = r_freq;
    w_pend_nxt  = r_pend_freq;
    w_timer_nxt = r_timer;
    w_clear     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_freq_nxt = w_target_run;
        if (i_en) begin
          w_state_nxt = S_RUN;
          w_clear     = 1'b1;
        end
      end

      S_RUN: begin
        if (!i_en) begin
          w_state_nxt = S_DRAIN;
          w_timer_nxt = '0;
        end else if (w_target_run != r_freq) begin
          w_pend_nxt  = w_target_run;
          w_timer_nxt = '0;
          w_state_nxt = S_PEND;
        end
      end

      S_PEND: begin
        w_pend_nxt  = w_target_pend;
        w_timer_nxt = w_timer_inc;
        // Disable wins over a coincident turn so the drain still waits for its own turn.
        if (!i_en) begin
          w_freq_nxt  = w_target_pend;
          w_timer_nxt = '0;
          w_state_nxt = S_DRAIN;
        end else if (w_turn_now || w_timeout) begin
          w_freq_nxt  = w_target_pend;
          w_state_nxt = S_RUN;
        end
      end

      S_DRAIN: begin
        w_freq_nxt  = w_target_run;
        w_timer_nxt = w_timer_inc;
        if (i_en) begin
          w_state_nxt = S_RUN;
        end else if (w_turn_now || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_freq      <= FREQ_RESET;
      r_pend_freq <= FREQ_RESET;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_freq      <= w_freq_nxt;
      r_pend_freq <= w_pend_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  assign o_start   = (r_state != S_IDLE);
  assign o_pending = (r_state == S_PEND);
  assign o_freq    = r_freq;

endmodule

// File: tb/tb_lfo_ctrl.sv
// Scoreboard bench for lfo_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lfo_ctrl;

  localparam int TIMEOUT = 60000;
  localparam int STEP    = 128854;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        dn;
  logic [31:0] lfo;
  logic        start;
  logic [2:0]  freq;
  logic        pending;
  logic        turn;

  lfo_ctrl #(
    .LFO_W          (32),
    .FREQ_RESET     (3'd0),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_rate_up   (up),
    .i_rate_down (dn),
    .i_lfo       (lfo),
    .o_start     (start),
    .o_freq      (freq),
    .o_pending   (pending),
    .o_turn      (turn)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum int {O_START, O_FREQ, O_PEND, O_TURN} sel_t;
  typedef struct {
    int unsigned cyc;
    string       name;
    sel_t        sel;
    int          val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int act(input sel_t s);
    case (s)
      O_START: return int'(start);
      O_FREQ:  return int'(freq);
      O_PEND:  return int'(pending);
      default: return int'(turn);
    endcase
  endfunction

  // Monitor: each expectation is tagged with the cycle whose outputs it describes.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   a;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      a = act(e.sel);
      n_cmp++;
      if (a != e.val) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
      end
    end
  end

  task automatic expect_one(input string name, input sel_t sel, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input int s, input int f, input int p, input int t);
    expect_one({tag, ".start"},   O_START, s);
    expect_one({tag, ".freq"},    O_FREQ,  f);
    expect_one({tag, ".pending"}, O_PEND,  p);
    expect_one({tag, ".turn"},    O_TURN,  t);
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge that sampled them.
  task automatic step(input logic e_i, input logic u, input logic d, input int l);
    en  = e_i;
    up  = u;
    dn  = d;
    lfo = 32'(l);
    @(posedge clk);
    #1;
    up = 1'b0;
    dn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; up = 1'b0; dn = 1'b0; lfo = '0;

    // Reset held for two edges with random inputs.
    for (int i = 0; i < 2; i++) begin
      en  = 1'($urandom);
      up  = 1'($urandom);
      dn  = 1'($urandom);
      lfo = $urandom;
      @(posedge clk);
      #1;
    end
    expect_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Idle rate stepping.
    step(0, 1, 0, 0); expect_one("idle_up1", O_FREQ, 1);
    step(0, 1, 0, 0); expect_one("idle_up2", O_FREQ, 2);
    step(0, 1, 0, 0); expect_one("idle_up3", O_FREQ, 3);
    // Reset glitch between edges must be ignored.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step(0, 0, 0, 0); expect_all("glitch", 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    expect_one("idle_down_to0", O_FREQ, 0);
    step(0, 0, 1, 0); expect_one("sat_lo", O_FREQ, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    expect_one("idle_up_to7", O_FREQ, 7);
    step(0, 1, 0, 0); expect_one("sat_hi", O_FREQ, 7);
    step(0, 1, 1, 0); expect_one("both_at7", O_FREQ, 7);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    expect_one("idle_down_to2", O_FREQ, 2);
    step(0, 1, 1, 0); expect_one("both_at2", O_FREQ, 2);

    // Deferred change on a rising ramp, committed at the falling sample.
    step(1, 0, 0, 0);        expect_all("def_en",    1, 2, 0, 0);
    step(1, 0, 0, STEP);     expect_all("def_r1",    1, 2, 0, 0);
    step(1, 0, 0, 2 * STEP); expect_all("def_r2",    1, 2, 0, 0);
    step(1, 1, 0, 3 * STEP); expect_all("def_up",    1, 2, 1, 0);
    step(1, 0, 0, 4 * STEP); expect_all("def_r4",    1, 2, 1, 0);
    step(1, 0, 0, 4 * STEP); expect_all("def_flat",  1, 2, 1, 0);
    step(1, 0, 0, 3 * STEP); expect_all("def_fall",  1, 3, 0, 1);
    step(1, 0, 0, 2 * STEP); expect_all("def_after", 1, 3, 0, 0);

    // Timeout with a constant LFO: commit lands exactly TIMEOUT edges after the pulse.
    step(1, 1, 0, 2 * STEP); expect_all("to_pulse", 1, 3, 1, 0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(1, 0, 0, 2 * STEP);
      expect_one("to_noturn", O_TURN, 0);
      if (k == TIMEOUT - 1) begin
        expect_one("to_before.freq", O_FREQ, 3);
        expect_one("to_before.pending", O_PEND, 1);
      end
      if (k == TIMEOUT) begin
        expect_one("to_commit.freq", O_FREQ, 4);
        expect_one("to_commit.pending", O_PEND, 0);
      end
    end

    // Drain: disable while pending commits at once, stop waits for the next turn.
    step(1, 1, 0, 2 * STEP); expect_all("dr_pend",  1, 4, 1, 0);
    step(0, 0, 0, 2 * STEP); expect_all("dr_off",   1, 5, 0, 0);
    step(0, 0, 0, 2 * STEP); expect_all("dr_wait",  1, 5, 0, 0);
    step(0, 0, 0, 3 * STEP); expect_all("dr_turn",  0, 5, 0, 1);

    // Re-enable mid-drain keeps the LFO running.
    step(1, 0, 0, 3 * STEP); expect_all("re_run",   1, 5, 0, 0);
    step(0, 0, 0, 3 * STEP); expect_all("re_drain", 1, 5, 0, 0);
    step(0, 0, 0, 4 * STEP); expect_all("re_first", 1, 5, 0, 0);
    step(1, 0, 0, 5 * STEP); expect_all("re_en",    1, 5, 0, 0);
    step(1, 0, 0, 4 * STEP); expect_all("re_turn",  1, 5, 0, 1);
    step(1, 0, 0, 4 * STEP); expect_all("re_flat",  1, 5, 0, 0);

    // Reset while pending, then the first direction after restart is not a turn.
    step(1, 1, 0, 4 * STEP); expect_all("rm_pend",  1, 5, 1, 0);
    rst_n = 1'b0;
    step(1, 0, 0, 4 * STEP); expect_all("rm_reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 4 * STEP); expect_all("rm_run",   1, 0, 0, 0);
    step(1, 0, 0, 3 * STEP); expect_all("rm_first", 1, 0, 0, 0);
    step(1, 0, 0, 2 * STEP); expect_all("rm_down",  1, 0, 0, 0);
    step(1, 0, 0, 3 * STEP); expect_all("rm_turn",  1, 0, 0, 1);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_queue: got %0d pending expectations expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
